pc_sequencer: RTL and testbench

Next-address and hold controller for the program counter. Each cycle it computes the next fetch address from the current PC and the decoded control-flow signals, and drives the `prox_end`/`halt` pair consumed by the PC register. A 4-state FSM handles the HALT instruction, stalls on an input (IN) instruction until the operator acknowledges, and holds for multi-cycle datapath stalls. It sits between the control unit/ALU and the PC register.

---
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next fetch address plus the HALT / IN / stall hold FSM.
// Optional committed-instruction counter is enabled by defining PCSEQ_RETIRE_CNT_EN.
module pc_sequencer #(
    parameter int unsigned PC_STEP = 1
) (
    input  logic        clock_pc,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [15:0] branch_off,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        halt_instr,
    input  logic        in_instr,
    input  logic        in_ack,
    input  logic        stall_req,
    input  logic        resume,
    output logic [31:0] prox_end,
    output logic        halt,
    output logic [1:0]  seq_state,
    output logic        waiting_input,
    output logic [31:0] retired
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned OFF_W  = 16;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        WAIT_IN = 2'b01,
        STALL   = 2'b10,
        HALTED  = 2'b11
    } seq_state_e;

    seq_state_e  state_q, state_d;
    logic        waiting_q, waiting_d;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] branch_sext;

    // Next fetch address, highest priority first: JR, J/JAL, taken branch, sequential.
    always_comb begin
        seq_addr    = pc + ADDR_W'(PC_STEP);
        branch_sext = {{(ADDR_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
        prox_end    = seq_addr;
        if (jr) begin
            prox_end = jr_target;
        end else if (jump) begin
            prox_end = {pc[31:26], jump_target};
        end else if (branch_taken) begin
            prox_end = seq_addr + branch_sext;
        end
    end

    // Hold decision and next state; the PC advances on the same edge a hold is released.
    always_comb begin
        state_d = state_q;
        halt    = 1'b1;
        unique case (state_q)
            RUN: begin
                halt = halt_instr | in_instr | stall_req;
                if (halt_instr) begin
                    state_d = HALTED;
                end else if (in_instr) begin
                    state_d = WAIT_IN;
                end else if (stall_req) begin
                    state_d = STALL;
                end
            end
            WAIT_IN: begin
                halt = ~in_ack;
                if (in_ack) begin
                    state_d = RUN;
                end
            end
            STALL: begin
                halt = stall_req;
                if (!stall_req) begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                halt = ~resume;
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                halt    = 1'b1;
                state_d = RUN;
            end
        endcase
        if (reset) begin
            halt    = 1'b1;
            state_d = RUN;
        end
        waiting_d = (state_d == WAIT_IN);
    end

    always_ff @(posedge clock_pc) begin
        if (reset) begin
            state_q   <= RUN;
            waiting_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waiting_q <= waiting_d;
        end
    end

    assign seq_state     = state_q;
    assign waiting_input = waiting_q;

`ifdef PCSEQ_RETIRE_CNT_EN
    logic [ADDR_W-1:0] retired_q, retired_d;
    logic              commit;

    // One retirement per edge on which the PC register accepts prox_end.
    always_comb begin
        commit    = ~reset & ~halt;
        retired_d = retired_q;
        if (commit) begin
            retired_d = retired_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clock_pc) begin
        if (reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`else
    assign retired = 32'h0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: address selection, HALT/IN/stall holds, reset and retire count.
module tb_pc_sequencer;

    logic        clock_pc;
    logic        reset;
    logic [31:0] pc;
    logic        branch_taken;
    logic [15:0] branch_off;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        halt_instr;
    logic        in_instr;
    logic        in_ack;
    logic        stall_req;
    logic        resume;
    logic [31:0] prox_end;
    logic        halt;
    logic [1:0]  seq_state;
    logic        waiting_input;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.PC_STEP(1)) dut (
        .clock_pc      (clock_pc),
        .reset         (reset),
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_off    (branch_off),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .halt_instr    (halt_instr),
        .in_instr      (in_instr),
        .in_ack        (in_ack),
        .stall_req     (stall_req),
        .resume        (resume),
        .prox_end      (prox_end),
        .halt          (halt),
        .seq_state     (seq_state),
        .waiting_input (waiting_input),
        .retired       (retired)
    );

    initial clock_pc = 1'b0;
    always #5 clock_pc = ~clock_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clock_pc);
        #1;
    endtask

    localparam logic [31:0] RET_EXP8 =
`ifdef PCSEQ_RETIRE_CNT_EN
        32'd8;
`else
        32'd0;
`endif

    initial begin
        reset = 1'b1; pc = 32'h0; branch_taken = 1'b0; branch_off = 16'h0;
        jump = 1'b0; jump_target = 26'h0; jr = 1'b0; jr_target = 32'h0;
        halt_instr = 1'b0; in_instr = 1'b0; in_ack = 1'b0; stall_req = 1'b0; resume = 1'b0;
        tick(); tick();
        chk("rst_state", 32'(seq_state), 32'd0);
        chk("rst_halt", 32'(halt), 32'd1);
        chk("rst_wait", 32'(waiting_input), 32'd0);
        chk("rst_retired", retired, 32'd0);

        reset = 1'b0;
        pc = 32'h10; #1;
        chk("seq_addr", prox_end, 32'h11);
        chk("seq_halt", 32'(halt), 32'd0);
        pc = 32'hFFFF_FFFF; #1;
        chk("seq_wrap", prox_end, 32'h0);

        pc = 32'h20; branch_off = 16'hFFFC; branch_taken = 1'b1; #1;
        chk("branch_back", prox_end, 32'h1D);
        jump = 1'b1; jump_target = 26'h40; #1;
        chk("jump_over_br", prox_end, 32'h40);
        jr = 1'b1; jr_target = 32'h1234; #1;
        chk("jr_over_all", prox_end, 32'h1234);
        pc = 32'hA000_0000; jr = 1'b0; #1;
        chk("jump_keeps_hi", prox_end, 32'hA000_0040);
        pc = 32'h20; branch_taken = 1'b0; jump = 1'b0; branch_off = 16'h0; #1;

        // HALT, with unrelated requests ignored while halted
        halt_instr = 1'b1; #1;
        chk("halt_in_run", 32'(halt), 32'd1);
        tick();
        halt_instr = 1'b0; in_ack = 1'b1; stall_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("halted_hold", 32'(halt), 32'd1);
            chk("halted_state", 32'(seq_state), 32'd3);
            tick();
        end
        in_ack = 1'b0; stall_req = 1'b0;
        resume = 1'b1; #1;
        chk("resume_halt", 32'(halt), 32'd0);
        tick();
        resume = 1'b0; #1;
        chk("resume_state", 32'(seq_state), 32'd0);

        // IN with a coincident ack that must be ignored
        in_instr = 1'b1; in_ack = 1'b1; #1;
        chk("in_halt", 32'(halt), 32'd1);
        tick();
        in_instr = 1'b0; in_ack = 1'b0; #1;
        chk("in_state", 32'(seq_state), 32'd1);
        chk("in_led", 32'(waiting_input), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("in_wait_halt", 32'(halt), 32'd1);
            tick();
        end
        in_ack = 1'b1; #1;
        chk("ack_halt", 32'(halt), 32'd0);
        tick();
        in_ack = 1'b0; #1;
        chk("ack_state", 32'(seq_state), 32'd0);
        chk("ack_led", 32'(waiting_input), 32'd0);
        chk("ack_run_halt", 32'(halt), 32'd0);

        // Three-edge stall
        stall_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_halt", 32'(halt), 32'd1);
            tick();
            chk("stall_state", 32'(seq_state), 32'd2);
        end
        stall_req = 1'b0; #1;
        chk("stall_release", 32'(halt), 32'd0);
        tick();
        chk("stall_exit", 32'(seq_state), 32'd0);

        // Reset during a stall
        stall_req = 1'b1; tick();
        chk("stall2_state", 32'(seq_state), 32'd2);
        reset = 1'b1; #1;
        chk("rst_forces_halt", 32'(halt), 32'd1);
        tick();
        reset = 1'b0; stall_req = 1'b0; #1;
        chk("rst_mid_state", 32'(seq_state), 32'd0);
        chk("rst_mid_retired", retired, 32'd0);

        // Retire count: 8 commits then a 2-edge stall
        for (int i = 0; i < 8; i++) tick();
        stall_req = 1'b1; tick(); tick();
        chk("stall_hold_state", 32'(seq_state), 32'd2);
        stall_req = 1'b0; #1;
        chk("retired_8", retired, RET_EXP8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
